writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 171 +++++++++++++++++
 tb/tb_writeback_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: buffers execute-stage writeback entries (three GPR writes plus EIP/EFLAGS)
// in a circular buffer and releases them one per permitted cycle through a registered output stage.
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_v,
    output logic                     in_rdy,
    input  logic                     in_gv0,
    input  logic                     in_gv1,
    input  logic                     in_gv2,
    input  logic [2:0]               in_gid0,
    input  logic [2:0]               in_gid1,
    input  logic [2:0]               in_gid2,
    input  logic [1:0]               in_gty0,
    input  logic [1:0]               in_gty1,
    input  logic [1:0]               in_gty2,
    input  logic [31:0]              in_gd0,
    input  logic [31:0]              in_gd1,
    input  logic [31:0]              in_gd2,
    input  logic                     in_ld_eip,
    input  logic                     in_ld_eflags,
    input  logic [31:0]              in_eip,
    input  logic [31:0]              in_eflags,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic [2:0]               wrgpr0,
    output logic [2:0]               wrgpr1,
    output logic [2:0]               wrgpr2,
    output logic [1:0]               gprwe0,
    output logic [1:0]               gprwe1,
    output logic [1:0]               gprwe2,
    output logic                     gprwv0,
    output logic                     gprwv1,
    output logic                     gprwv2,
    output logic [31:0]              gpr_din0,
    output logic [31:0]              gpr_din1,
    output logic [31:0]              gpr_din2,
    output logic                     ld_eip,
    output logic                     ld_eflags,
    output logic [31:0]              eip_din,
    output logic [31:0]              eflags_din,
    output logic [7:0]               busy_gpr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DepthC = DEPTH[PW:0];

    typedef struct packed {
        logic [2:0]        gv;
        logic [2:0][2:0]   gid;
        logic [2:0][1:0]   gty;
        logic [2:0][31:0]  gd;
        logic              ld_eip;
        logic              ld_eflags;
        logic [31:0]       eip;
        logic [31:0]       eflags;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          stage_q;
    entry_t          in_entry;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [PW:0]     count_q;
    logic [PW-1:0]   offset;
    logic            push;
    logic            pop;

    // Higher-numbered port wins on a duplicate id, so lower duplicates are dropped before storage.
    always_comb begin
        in_entry           = '0;
        in_entry.gid       = {in_gid2, in_gid1, in_gid0};
        in_entry.gty       = {in_gty2, in_gty1, in_gty0};
        in_entry.gd        = {in_gd2, in_gd1, in_gd0};
        in_entry.ld_eip    = in_ld_eip;
        in_entry.ld_eflags = in_ld_eflags;
        in_entry.eip       = in_eip;
        in_entry.eflags    = in_eflags;
        in_entry.gv[2]     = in_gv2;
        in_entry.gv[1]     = in_gv1 & ~(in_gv2 && (in_gid2 == in_gid1));
        in_entry.gv[0]     = in_gv0 & ~(in_gv1 && (in_gid1 == in_gid0))
                                    & ~(in_gv2 && (in_gid2 == in_gid0));
    end

    assign in_rdy = (count_q < DepthC);
    assign push   = in_v & in_rdy & ~flush;
    assign pop    = (count_q != '0) & drain_en & ~flush;

    always_ff @(posedge clk) begin
        if (!clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stage_q <= '0;
        end else if (flush) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            stage_q.gv        <= '0;
            stage_q.ld_eip    <= 1'b0;
            stage_q.ld_eflags <= 1'b0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q  <= head_q + PW'(1);
                stage_q <= mem_q[head_q];
            end else begin
                // Strobes are single-cycle; payload fields hold.
                stage_q.gv        <= '0;
                stage_q.ld_eip    <= 1'b0;
                stage_q.ld_eflags <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr && push) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    // Derived purely from registered state, so it tracks count on the same cycle.
    always_comb begin
        busy_gpr = '0;
        offset   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PW'(i) - head_q;
            if ({1'b0, offset} < count_q) begin
                for (int p = 0; p < 3; p++) begin
                    if (mem_q[i].gv[p]) begin
                        busy_gpr[mem_q[i].gid[p]] = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (stage_q.gv[p]) begin
                busy_gpr[stage_q.gid[p]] = 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign wrgpr0     = stage_q.gid[0];
    assign wrgpr1     = stage_q.gid[1];
    assign wrgpr2     = stage_q.gid[2];
    assign gprwe0     = stage_q.gty[0];
    assign gprwe1     = stage_q.gty[1];
    assign gprwe2     = stage_q.gty[2];
    assign gprwv0     = stage_q.gv[0];
    assign gprwv1     = stage_q.gv[1];
    assign gprwv2     = stage_q.gv[2];
    assign gpr_din0   = stage_q.gd[0];
    assign gpr_din1   = stage_q.gd[1];
    assign gpr_din2   = stage_q.gd[2];
    assign ld_eip     = stage_q.ld_eip;
    assign ld_eflags  = stage_q.ld_eflags;
    assign eip_din    = stage_q.eip;
    assign eflags_din = stage_q.eflags;

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue-based reference model predicts every cycle's
// outputs; a negedge monitor pops predictions and compares them with the DUT.
module tb_writeback_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [2:0]  gv;
        logic [8:0]  gid;
        logic [5:0]  gty;
        logic [95:0] gd;
        logic        le;
        logic        lf;
        logic [31:0] eip;
        logic [31:0] efl;
    } ent_t;

    typedef struct packed {
        logic [2:0]   cnt;
        logic         rdy;
        logic [7:0]   busy;
        logic [4:0]   strb;
        logic [110:0] gfld;
        logic [63:0]  ef;
    } snap_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic in_v = 1'b0;
    logic in_rdy;
    logic in_gv0 = 1'b0, in_gv1 = 1'b0, in_gv2 = 1'b0;
    logic [2:0] in_gid0 = '0, in_gid1 = '0, in_gid2 = '0;
    logic [1:0] in_gty0 = '0, in_gty1 = '0, in_gty2 = '0;
    logic [31:0] in_gd0 = '0, in_gd1 = '0, in_gd2 = '0;
    logic in_ld_eip = 1'b0, in_ld_eflags = 1'b0;
    logic [31:0] in_eip = '0, in_eflags = '0;
    logic drain_en = 1'b0;
    logic flush = 1'b0;
    logic [2:0] wrgpr0, wrgpr1, wrgpr2;
    logic [1:0] gprwe0, gprwe1, gprwe2;
    logic gprwv0, gprwv1, gprwv2;
    logic [31:0] gpr_din0, gpr_din1, gpr_din2;
    logic ld_eip, ld_eflags;
    logic [31:0] eip_din, eflags_din;
    logic [7:0] busy_gpr;
    logic [2:0] count;

    int n_vec = 0;
    int n_bad = 0;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .in_v(in_v), .in_rdy(in_rdy),
        .in_gv0(in_gv0), .in_gv1(in_gv1), .in_gv2(in_gv2),
        .in_gid0(in_gid0), .in_gid1(in_gid1), .in_gid2(in_gid2),
        .in_gty0(in_gty0), .in_gty1(in_gty1), .in_gty2(in_gty2),
        .in_gd0(in_gd0), .in_gd1(in_gd1), .in_gd2(in_gd2),
        .in_ld_eip(in_ld_eip), .in_ld_eflags(in_ld_eflags),
        .in_eip(in_eip), .in_eflags(in_eflags),
        .drain_en(drain_en), .flush(flush),
        .wrgpr0(wrgpr0), .wrgpr1(wrgpr1), .wrgpr2(wrgpr2),
        .gprwe0(gprwe0), .gprwe1(gprwe1), .gprwe2(gprwe2),
        .gprwv0(gprwv0), .gprwv1(gprwv1), .gprwv2(gprwv2),
        .gpr_din0(gpr_din0), .gpr_din1(gpr_din1), .gpr_din2(gpr_din2),
        .ld_eip(ld_eip), .ld_eflags(ld_eflags),
        .eip_din(eip_din), .eflags_din(eflags_din),
        .busy_gpr(busy_gpr), .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    ent_t  mq[$];
    ent_t  mstage = '0;
    snap_t expq[$];
    logic  m_pushed = 1'b0;

    function automatic ent_t sample_in();
        ent_t e;
        e.gid = {in_gid2, in_gid1, in_gid0};
        e.gty = {in_gty2, in_gty1, in_gty0};
        e.gd  = {in_gd2, in_gd1, in_gd0};
        e.le  = in_ld_eip;
        e.lf  = in_ld_eflags;
        e.eip = in_eip;
        e.efl = in_eflags;
        e.gv  = {in_gv2, in_gv1, in_gv0};
        // A port is written only if no higher port targets the same register.
        for (int p = 0; p < 3; p++)
            for (int q = p + 1; q < 3; q++)
                if (e.gv[q] && e.gid[q*3 +: 3] == e.gid[p*3 +: 3]) e.gv[p] = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] writes_of(input ent_t e);
        logic [7:0] b = '0;
        for (int p = 0; p < 3; p++)
            if (e.gv[p]) b[e.gid[p*3 +: 3]] = 1'b1;
        return b;
    endfunction

    initial begin
        forever begin
            ent_t  e;
            snap_t s;
            bit    do_pop, do_push;
            @(posedge clk);
            m_pushed = 1'b0;
            if (!clr) begin
                mq.delete();
                mstage = '0;
            end else if (flush) begin
                mq.delete();
                mstage.gv = '0;
                mstage.le = 1'b0;
                mstage.lf = 1'b0;
            end else begin
                do_pop  = (mq.size() > 0) && drain_en;
                do_push = in_v && (mq.size() < DEPTH);
                e = sample_in();
                if (do_pop) begin
                    mstage = mq.pop_front();
                end else begin
                    mstage.gv = '0;
                    mstage.le = 1'b0;
                    mstage.lf = 1'b0;
                end
                if (do_push) begin
                    mq.push_back(e);
                    m_pushed = 1'b1;
                end
            end
            s.cnt  = 3'(mq.size());
            s.rdy  = (mq.size() < DEPTH);
            s.busy = writes_of(mstage);
            foreach (mq[i]) s.busy |= writes_of(mq[i]);
            s.strb = {mstage.gv, mstage.le, mstage.lf};
            s.gfld = {mstage.gid, mstage.gty, mstage.gd};
            s.ef   = {mstage.eip, mstage.efl};
            expq.push_back(s);
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            snap_t s;
            @(negedge clk);
            if (expq.size() > 0) begin
                s = expq.pop_front();
                chk("count", 128'(count), 128'(s.cnt));
                chk("in_rdy", 128'(in_rdy), 128'(s.rdy));
                chk("busy_gpr", 128'(busy_gpr), 128'(s.busy));
                chk("strobes", 128'({gprwv2, gprwv1, gprwv0, ld_eip, ld_eflags}), 128'(s.strb));
                chk("gpr_fields", 128'({wrgpr2, wrgpr1, wrgpr0, gprwe2, gprwe1, gprwe0,
                                        gpr_din2, gpr_din1, gpr_din0}), 128'(s.gfld));
                chk("eip_eflags", 128'({eip_din, eflags_din}), 128'(s.ef));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input ent_t e);
        {in_gv2, in_gv1, in_gv0}    = e.gv;
        {in_gid2, in_gid1, in_gid0} = e.gid;
        {in_gty2, in_gty1, in_gty0} = e.gty;
        {in_gd2, in_gd1, in_gd0}    = e.gd;
        in_ld_eip    = e.le;
        in_ld_eflags = e.lf;
        in_eip       = e.eip;
        in_eflags    = e.efl;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.gv  = 3'($urandom);
        e.gid = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
        e.gty = 6'($urandom);
        e.gd  = {$urandom, $urandom, $urandom};
        e.le  = 1'($urandom);
        e.lf  = 1'($urandom);
        e.eip = $urandom;
        e.efl = $urandom;
        return e;
    endfunction

    // Present an entry until the model says it was accepted, bounded.
    task automatic push_entry(input ent_t e);
        bit ok = 1'b0;
        set_in(e);
        in_v = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            tick();
            ok = m_pushed;
        end
        in_v = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: got not accepted, expected accepted within 64 cycles");
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) push_entry(rand_ent());
    endtask

    initial begin
        ent_t e;
        // Reset with an entry presented; it must be dropped.
        set_in(rand_ent());
        in_v = 1'b1;
        drain_en = 1'b1;
        tick(); tick();
        in_v = 1'b0;
        clr = 1'b1;
        tick();

        // Single GPR write through an empty queue.
        e = '0;
        e.gv = 3'b001; e.gid = 9'd3; e.gty = 6'b000011; e.gd = 96'hDEADBEEF;
        push_entry(e);
        repeat (3) tick();

        // Fill to full with drain held off, fifth entry waits for space.
        drain_en = 1'b0;
        fill(4);
        set_in(rand_ent());
        in_v = 1'b1;
        repeat (3) tick();
        drain_en = 1'b1;
        in_v = 1'b0;
        push_entry(rand_ent());
        repeat (6) tick();

        // Steady state at two entries with push and pop every cycle, across pointer wrap.
        drain_en = 1'b0;
        fill(2);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) push_entry(rand_ent());
        repeat (4) tick();

        // Duplicate id across ports 0 and 2.
        e = '0;
        e.gv = 3'b101; e.gid = {3'd1, 3'd0, 3'd1}; e.gd = {32'h22, 32'h0, 32'h11};
        push_entry(e);
        // Entry with no valid fields.
        push_entry('0);
        repeat (3) tick();

        // Flush with three queued and a new entry presented.
        drain_en = 1'b0;
        fill(3);
        set_in(rand_ent());
        in_v = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_v = 1'b0;
        drain_en = 1'b1;
        repeat (3) tick();

        // Reset mid-drain.
        drain_en = 1'b0;
        fill(4);
        drain_en = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        repeat (6) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            set_in(rand_ent());
            in_v     = 1'($urandom_range(0, 1));
            drain_en = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            clr      = ($urandom_range(0, 63) != 0);
            tick();
        end
        clr = 1'b1;
        flush = 1'b0;
        in_v = 1'b0;
        drain_en = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
